// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run controller for a downstream 4-bit down counter.
// Divides clk by (presc_div+1) to produce tick_en. It watches the counter's
// underflow flag to finish a one-shot run or to count wraps in periodic mode.
// Handshake note: this block has no valid/ready channels. start is a
// request sampled only in IDLE, and stop/hold are levels sampled every cycle.
// The tick_en output qualifies every underflow_in observation.
module countdown_ctrl #(
  parameter int PRESC_W = 8,
  parameter int WRAP_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               periodic,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               underflow_in,
  output logic               tick_en,
  output logic               busy,
  output logic               done,
  output logic [WRAP_W-1:0]  wrap_cnt,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] pcnt;
  logic [PRESC_W-1:0] div_q;
  logic               per_q;
  logic               wrap_ev;
  logic               wrap_full;

  // Tick only while actively running; stop and hold mask it within the same cycle.
  assign tick_en   = (state == RUN) && (pcnt == '0) && !hold && !stop;
  // Underflow is meaningful only on a cycle the counter is actually enabled.
  assign wrap_ev   = tick_en && underflow_in;
  assign wrap_full = &wrap_cnt;
  assign fsm_state = state;

  // Run-control FSM together with the prescaler, wrap counter and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      div_q    <= '0;
      per_q    <= 1'b0;
      wrap_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state    <= RUN;
            busy     <= 1'b1;
            div_q    <= presc_div;
            per_q    <= periodic;
            pcnt     <= presc_div;
            wrap_cnt <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (hold) begin
            // The prescaler freezes from this cycle on, so the phase survives the hold.
            state <= HOLD;
          end else begin
            pcnt <= (pcnt == '0) ? div_q : pcnt - 1'b1;
            if (wrap_ev && !wrap_full) begin
              wrap_cnt <= wrap_cnt + 1'b1;
            end
            if (wrap_ev && !per_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!hold) begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl. Each DUT drives a 4-bit down counter model that
// shares the DUT reset. A second instance uses WRAP_W=2 for the saturation check.
module tb_countdown_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       hold;
  logic       periodic;
  logic [7:0] presc_div;

  logic       tick_a, busy_a, done_a, tick_b, busy_b, done_b;
  logic [7:0] wrap_a;
  logic [1:0] wrap_b;
  logic [1:0] st_a, st_b;
  logic [3:0] cnt_a, cnt_b;
  logic       under_a, under_b;

  int checks;
  int failures;
  int done_cnt;
  int done_cyc;
  logic [31:0] exp_q[$];

  typedef struct {
    int presc;
    bit per;
    int win;
    int n_ticks;
    int done_at;
    int exp_wrap;
    int exp_busy;
    int exp_cnt;
  } vec_t;
  vec_t vecs[5];

  countdown_ctrl #(.PRESC_W(8), .WRAP_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .periodic(periodic), .presc_div(presc_div), .underflow_in(under_a),
    .tick_en(tick_a), .busy(busy_a), .done(done_a), .wrap_cnt(wrap_a),
    .fsm_state(st_a)
  );

  countdown_ctrl #(.PRESC_W(8), .WRAP_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .periodic(periodic), .presc_div(presc_div), .underflow_in(under_b),
    .tick_en(tick_b), .busy(busy_b), .done(done_b), .wrap_cnt(wrap_b),
    .fsm_state(st_b)
  );

  // Down counter models on the shared reset net.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 4'hF;
      cnt_b <= 4'hF;
    end else begin
      if (tick_a) cnt_a <= cnt_a - 4'd1;
      if (tick_b) cnt_b <= cnt_b - 4'd1;
    end
  end
  assign under_a = (cnt_a == 4'd0);
  assign under_b = (cnt_b == 4'd0);

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    periodic = 1'b0; presc_div = 8'd0;
    #2;
    check("rst_tick", {31'd0, tick_a}, 0);
    check("rst_busy", {31'd0, busy_a}, 0);
    check("rst_done", {31'd0, done_a}, 0);
    check("rst_wrap", {24'd0, wrap_a}, 0);
    check("rst_state", {30'd0, st_a}, 0);
    check("rst_cnt", {28'd0, cnt_a}, 15);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called #1 after an edge; the next edge is the start edge.
  task automatic start_run(input int presc, input bit per);
    presc_div = 8'(presc);
    periodic  = per;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Observes cycles k_first..k_last; ticks are scored against exp_q.
  task automatic run_window(input int k_first, input int k_last, input int hold_from,
                            input int hold_to, input int restart_at);
    logic [31:0] e;
    hold = (k_first >= hold_from) && (k_first <= hold_to);
    for (int k = k_first; k <= k_last; k++) begin
      if (k == restart_at) begin
        start = 1'b1; presc_div = 8'd5; periodic = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (tick_a) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
        check("tick_cycle", k, e);
      end
      if (done_a) begin
        done_cnt++;
        done_cyc = k;
      end
      @(posedge clk); #1;
      hold = ((k + 1) >= hold_from) && ((k + 1) <= hold_to);
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic stop_cycle(input int exp_wrap, input int exp_cnt);
    stop = 1'b1;
    @(negedge clk);
    check("stop_tick", {31'd0, tick_a}, 0);
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_busy", {31'd0, busy_a}, 0);
    check("stop_done", {31'd0, done_a}, 0);
    check("stop_wrap", {24'd0, wrap_a}, 32'(exp_wrap));
    check("stop_cnt", {28'd0, cnt_a}, 32'(exp_cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0; done_cyc = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    periodic = 1'b0; presc_div = 8'd0;

    //          presc per win ticks done wrap busy cnt
    vecs[0] = '{0, 1'b0, 20, 16, 17, 1, 0, 15};
    vecs[1] = '{3, 1'b0, 70, 16, 65, 1, 0, 15};
    vecs[2] = '{1, 1'b0, 40, 16, 33, 1, 0, 15};
    vecs[3] = '{0, 1'b1, 35, 35, 0,  2, 1, 12};
    vecs[4] = '{2, 1'b1, 50, 16, 0,  1, 1, 15};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      exp_q.delete();
      for (int m = 1; m <= vecs[i].n_ticks; m++) exp_q.push_back(32'((vecs[i].presc + 1) * m));
      done_cnt = 0; done_cyc = 0;
      start_run(vecs[i].presc, vecs[i].per);
      run_window(1, vecs[i].win, 0, -1, 0);
      check("ticks_missing", exp_q.size(), 0);
      check("done_count", done_cnt, (vecs[i].done_at != 0) ? 1 : 0);
      check("done_cycle", done_cyc, 32'(vecs[i].done_at));
      check("end_busy", {31'd0, busy_a}, 32'(vecs[i].exp_busy));
      check("end_wrap", {24'd0, wrap_a}, 32'(vecs[i].exp_wrap));
      check("end_cnt", {28'd0, cnt_a}, 32'(vecs[i].exp_cnt));
      stop_cycle(vecs[i].exp_wrap, vecs[i].exp_cnt);
    end

    // start is ignored while in DONE.
    do_reset();
    exp_q.delete();
    for (int m = 1; m <= 16; m++) exp_q.push_back(32'(m));
    start_run(0, 1'b0);
    run_window(1, 16, 0, -1, 0);
    start = 1'b1;
    @(negedge clk);
    check("done_pulse", {31'd0, done_a}, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_start_ign_busy", {31'd0, busy_a}, 0);
    check("done_start_ign_state", {30'd0, st_a}, 0);
    @(posedge clk); #1;

    // start together with stop in IDLE: stop wins.
    do_reset();
    exp_q.delete();
    presc_div = 8'd0; periodic = 1'b0; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    run_window(1, 5, 0, -1, 0);
    check("startstop_busy", {31'd0, busy_a}, 0);
    check("startstop_state", {30'd0, st_a}, 0);

    // Hold for cycles 4..8 with presc 2: the phase resumes after release.
    do_reset();
    exp_q.delete();
    exp_q.push_back(3); exp_q.push_back(12); exp_q.push_back(15); exp_q.push_back(18);
    start_run(2, 1'b0);
    run_window(1, 6, 4, 8, 0);
    check("hold_state", {30'd0, st_a}, 2);
    check("hold_busy", {31'd0, busy_a}, 1);
    run_window(7, 20, 4, 8, 0);
    check("hold_ticks_missing", exp_q.size(), 0);
    stop_cycle(0, 11);

    // Five wraps: saturating 2-bit counter, and a restart mid-run is ignored.
    do_reset();
    exp_q.delete();
    for (int m = 1; m <= 80; m++) exp_q.push_back(32'(m));
    done_cnt = 0;
    start_run(0, 1'b1);
    run_window(1, 80, 0, -1, 40);
    check("sat_ticks_missing", exp_q.size(), 0);
    check("sat_wrap_a", {24'd0, wrap_a}, 5);
    check("sat_wrap_b", {30'd0, wrap_b}, 3);
    check("sat_busy", {31'd0, busy_b}, 1);
    check("sat_done", done_cnt, 0);
    stop_cycle(5, 15);

    // Asynchronous reset mid-run while tick_en is high.
    do_reset();
    exp_q.delete();
    for (int m = 1; m <= 19; m++) exp_q.push_back(32'(m));
    start_run(0, 1'b1);
    run_window(1, 19, 0, -1, 0);
    #2;
    check("prerst_tick", {31'd0, tick_a}, 1);
    check("prerst_wrap", {24'd0, wrap_a}, 1);
    rst_n = 1'b0;
    #1;
    check("arst_tick", {31'd0, tick_a}, 0);
    check("arst_busy", {31'd0, busy_a}, 0);
    check("arst_wrap_a", {24'd0, wrap_a}, 0);
    check("arst_wrap_b", {30'd0, wrap_b}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    run_window(1, 4, 0, -1, 0);
    check("postrst_busy", {31'd0, busy_a}, 0);
    check("postrst_state", {30'd0, st_a}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
